// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Purpose  : Registered N-channel multiplexer. A channel is chosen either
//            from an external select (manual) or by stepping through every
//            channel in turn (scan). The chosen channel is sampled after a
//            programmable dwell time and offered on a valid/ready output.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_data    - CHANNELS*WIDTH packed inputs, channel k at
//                         [k*WIDTH +: WIDTH]
//            en         - run enable
//            mode       - 0 = manual (sel), 1 = scan (auto-increment)
//            sel        - manual channel select (clamped to CHANNELS-1)
//            out_data   - sampled channel data
//            out_ch     - index of the sampled channel
//            out_valid  - out_data/out_ch hold a sample
//            out_ready  - consumer accepts the sample
//            wrap       - one-cycle pulse when the scan pointer wraps to 0
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] c_ch_last  = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DWELL   = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_cur_ch;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic                r_out_valid;
    logic                r_wrap;

    logic [WIDTH-1:0]    w_ch_data [CHANNELS];
    logic [SEL_W-1:0]    w_eff_ch;
    logic [WIDTH-1:0]    w_eff_data;
    logic [SEL_W-1:0]    w_next_ch;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Effective channel at the sampling edge: scan pointer or clamped select.
    always_comb begin
        w_eff_ch = r_cur_ch;
        if (!mode) begin
            w_eff_ch = (sel > c_ch_last) ? c_ch_last : sel;
        end
    end

    // Compare-and-select keeps the lookup safe when SEL_W can address more
    // entries than exist.
    always_comb begin
        w_eff_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_eff_ch == SEL_W'(k)) begin
                w_eff_data = w_ch_data[k];
            end
        end
    end

    // Successor of the channel just handed off; derived from out_ch so the
    // pointer only advances once the consumer has taken the sample.
    assign w_next_ch = (r_out_ch == c_ch_last) ? '0 : r_out_ch + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur_ch    <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (en) begin
                        r_state <= S_DWELL;
                        r_cnt   <= '0;
                    end
                end
                S_DWELL: begin
                    if (!en) begin
                        // Abort: nothing captured, pointer untouched.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_out_data  <= w_eff_data;
                        r_out_ch    <= w_eff_ch;
                        r_out_valid <= 1'b1;
                        r_state     <= S_PRESENT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PRESENT: begin
                    // en is ignored here: a pending sample always completes.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (mode) begin
                            r_cur_ch <= w_next_ch;
                            r_wrap   <= (r_out_ch == c_ch_last);
                        end else begin
                            r_cur_ch <= r_out_ch;
                        end
                        r_cnt   <= '0;
                        r_state <= en ? S_DWELL : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan
// Purpose  : Self-checking bench for mux_scan. Two instances share one
//            stimulus stream: default parameters, and WIDTH=8 / CHANNELS=5 /
//            SEL_W=3 / DWELL=1 (which also exercises select clamping).
//            A transaction-level reference model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [39:0] din;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic        out_ready;

    logic [3:0]  d0_data;
    logic [1:0]  d0_ch;
    logic        d0_valid;
    logic        d0_wrap;
    logic [7:0]  d1_data;
    logic [2:0]  d1_ch;
    logic        d1_valid;
    logic        d1_wrap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(din[15:0]), .en(en), .mode(mode),
        .sel(sel[1:0]), .out_data(d0_data), .out_ch(d0_ch),
        .out_valid(d0_valid), .out_ready(out_ready), .wrap(d0_wrap)
    );

    mux_scan #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(din), .en(en), .mode(mode),
        .sel(sel), .out_data(d1_data), .out_ch(d1_ch),
        .out_valid(d1_valid), .out_ready(out_ready), .wrap(d1_wrap)
    );

    // ---------------- reference model (one slot per instance) -------------
    int pw[2] = '{4, 8};
    int pc[2] = '{4, 5};
    int pd[2] = '{4, 1};

    // phase: 0 idle, 1 dwelling, 2 presenting; left = edges until sampling
    int m_phase[2], m_left[2], m_cur[2], m_v[2], m_d[2], m_ch[2], m_wr[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_left[i] = 0; m_cur[i] = 0;
            m_v[i] = 0; m_d[i] = 0; m_ch[i] = 0; m_wr[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        longint unsigned dv;
        int s;
        m_wr[i] = 0;
        case (m_phase[i])
            0: if (en) begin m_phase[i] = 1; m_left[i] = pd[i]; end
            1: begin
                if (!en) m_phase[i] = 0;
                else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        s = (i == 0) ? int'(sel[1:0]) : int'(sel);
                        if (s > pc[i] - 1) s = pc[i] - 1;
                        if (mode) s = m_cur[i];
                        dv = 64'(din);
                        m_d[i]  = int'((dv >> (s * pw[i])) & ((64'd1 << pw[i]) - 1));
                        m_ch[i] = s;
                        m_v[i]  = 1;
                        m_phase[i] = 2;
                    end
                end
            end
            default: if (out_ready) begin
                m_v[i] = 0;
                if (mode) begin
                    m_wr[i]  = (m_ch[i] == pc[i] - 1) ? 1 : 0;
                    m_cur[i] = (m_ch[i] + 1) % pc[i];
                end else begin
                    m_cur[i] = m_ch[i];
                end
                m_phase[i] = en ? 1 : 0;
                m_left[i]  = pd[i];
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("d0.valid", 32'(d0_valid), m_v[0]);
        check("d0.wrap",  32'(d0_wrap),  m_wr[0]);
        if (m_v[0] != 0) begin
            check("d0.data", 32'(d0_data), m_d[0]);
            check("d0.ch",   32'(d0_ch),   m_ch[0]);
        end
        check("d1.valid", 32'(d1_valid), m_v[1]);
        check("d1.wrap",  32'(d1_wrap),  m_wr[1]);
        if (m_v[1] != 0) begin
            check("d1.data", 32'(d1_data), m_d[1]);
            check("d1.ch",   32'(d1_ch),   m_ch[1]);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".d0valid"}, 32'(d0_valid), 0);
        check({tag, ".d0data"},  32'(d0_data),  0);
        check({tag, ".d0ch"},    32'(d0_ch),    0);
        check({tag, ".d0wrap"},  32'(d0_wrap),  0);
        check({tag, ".d1valid"}, 32'(d1_valid), 0);
        check({tag, ".d1data"},  32'(d1_data),  0);
        check({tag, ".d1ch"},    32'(d1_ch),    0);
        check({tag, ".d1wrap"},  32'(d1_wrap),  0);
    endtask

    initial begin
        int seen_d[$];
        int seen_c[$];
        int wraps;
        int held_ch;
        int got;
        int exp_d[5] = '{1, 2, 3, 4, 1};
        int exp_c[5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; din = '0; en = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        model_reset();
        #2;
        check_zero("rst0");
        do_reset();

        // ---- manual mode, latency and select change during dwell ----
        din = 40'h00_0000_D5A3; sel = 3'd2; mode = 1'b0; out_ready = 1'b1; en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("man1.valid", 32'(d0_valid), 1);
        check("man1.data",  32'(d0_data),  4'h5);
        check("man1.ch",    32'(d0_ch),    2);
        tick();
        sel = 3'd1;
        for (int k = 0; k < 4; k++) tick();
        check("man2.valid", 32'(d0_valid), 1);
        check("man2.data",  32'(d0_data),  4'hA);
        check("man2.ch",    32'(d0_ch),    1);

        // ---- scan with wrap ----
        do_reset();
        din = 40'h55_4433_4321; mode = 1'b1; out_ready = 1'b1; en = 1'b1;
        wraps = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (d0_valid) begin seen_d.push_back(int'(d0_data)); seen_c.push_back(int'(d0_ch)); end
            if (d0_wrap) wraps++;
        end
        check("scan.count", seen_d.size(), 5);
        for (int k = 0; k < 5 && k < seen_d.size(); k++) begin
            check("scan.data", seen_d[k], exp_d[k]);
            check("scan.ch",   seen_c[k], exp_c[k]);
        end
        check("scan.wraps", wraps, 1);

        // ---- back-pressure with in_data toggling ----
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin tick(); got = int'(d0_valid); end
        out_ready = 1'b0;
        held_ch = int'(d0_ch);
        for (int k = 0; k < 10; k++) begin
            din = {$urandom(), $urandom()};
            tick();
        end
        check("bp.valid", 32'(d0_valid), 1);
        check("bp.ch",    32'(d0_ch),    held_ch);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin tick(); got = int'(d0_valid); end
        check("bp.next_seen", got, 1);
        check("bp.next_ch",   32'(d0_ch), (held_ch + 1) % 4);

        // ---- abort during dwell, then manual clamp ----
        tick();
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("abort.valid", 32'(d0_valid), 0);
        mode = 1'b0; sel = 3'd7; en = 1'b1;
        din = 40'hC4_B3A2_9180;
        for (int k = 0; k < 6; k++) tick();
        check("clamp.ch",   32'(d1_ch),   4);
        check("clamp.data", 32'(d1_data), 8'hC4);

        // ---- asynchronous reset mid-PRESENT ----
        out_ready = 1'b0; mode = 1'b1;
        for (int k = 0; k < 20 && m_v[0] == 0; k++) tick();
        check("arst.pre_valid", 32'(d0_valid), 1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_zero("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("arst.idle", 32'(d0_valid), 0);

        // ---- randomized operation ----
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(0, 9) != 0);
            mode      = ($urandom_range(0, 3) != 0) ? mode : ~mode;
            sel       = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            din       = {8'($urandom()), $urandom()};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
